// File: rtl/fir_out_requant_decim.sv
// Decimates full-precision FIR output, rounds/saturates kept samples and buffers them in a ready/valid FIFO.
// Optional FIR_REQUANT_CONVERGENT_EN selects round-half-to-even in place of round-half-up.
module fir_out_requant_decim #(
  parameter int INPUT_WIDTH  = 33,
  parameter int OUTPUT_WIDTH = 16,
  parameter int FRAC_SHIFT   = 15,
  parameter int DECIM_FACTOR = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INPUT_WIDTH-1:0]        din,
  input  logic                          din_valid,
  output logic [OUTPUT_WIDTH-1:0]       dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          sat_pulse,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM_FACTOR - 1);
  localparam logic [INPUT_WIDTH:0] HALF = {{INPUT_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  logic [PW-1:0]             r_phase;
  logic [INPUT_WIDTH-1:0]    r_a_data;
  logic                      r_a_vld;
  logic [INPUT_WIDTH:0]      r_b_data;
  logic                      r_b_vld;
  logic [OUTPUT_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_rptr;
  logic [AW:0]               r_fill;
  logic                      r_sat;
  logic                      r_ovf;

  logic                      w_keep;
  logic [INPUT_WIDTH:0]      w_ext;
  logic signed [INPUT_WIDTH:0] w_sum;
  logic [INPUT_WIDTH:0]      w_shr;
  logic [INPUT_WIDTH:0]      w_rnd;
  logic [INPUT_WIDTH-OUTPUT_WIDTH+1:0] w_hi;
  logic                      w_clip;
  logic [OUTPUT_WIDTH-1:0]   w_sat;
  logic                      w_full;
  logic                      w_rd;
  logic                      w_wr;
  logic                      w_drop;

  assign w_keep = din_valid && (r_phase == '0);

  // One extra bit of headroom so adding the half-LSB can never wrap.
  assign w_ext = {r_a_data[INPUT_WIDTH-1], r_a_data};
  assign w_sum = $signed(w_ext + HALF);
  assign w_shr = w_sum >>> FRAC_SHIFT;

`ifdef FIR_REQUANT_CONVERGENT_EN
  logic w_tie;
  // On an exact tie half-up lands on floor+1; clearing the LSB picks the even neighbour.
  assign w_tie = (w_ext[FRAC_SHIFT-1:0] == HALF[FRAC_SHIFT-1:0]);
  assign w_rnd = w_tie ? {w_shr[INPUT_WIDTH:1], 1'b0} : w_shr;
`else
  assign w_rnd = w_shr;
`endif

  // In range only when every bit above the output MSB matches the sign.
  assign w_hi   = r_b_data[INPUT_WIDTH:OUTPUT_WIDTH-1];
  assign w_clip = !((&w_hi) || !(|w_hi));
  assign w_sat  = !w_clip ? r_b_data[OUTPUT_WIDTH-1:0]
                : (r_b_data[INPUT_WIDTH] ? OUT_MIN : OUT_MAX);

  assign w_full = (r_fill == FULL);
  assign w_rd   = dout_valid && dout_ready;
  assign w_wr   = r_b_vld && (!w_full || w_rd);
  assign w_drop = r_b_vld && w_full && !w_rd;

  assign dout_valid = (r_fill != '0);
  assign dout       = dout_valid ? r_mem[r_rptr] : '0;
  assign sat_pulse  = r_sat;
  assign overflow   = r_ovf;
  assign fill       = r_fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase  <= '0;
      r_a_data <= '0;
      r_a_vld  <= 1'b0;
      r_b_data <= '0;
      r_b_vld  <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fill   <= '0;
      r_sat    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (din_valid)
        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      r_a_data <= din;
      r_a_vld  <= w_keep;
      r_b_data <= w_rnd;
      r_b_vld  <= r_a_vld;
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      r_sat <= w_wr && w_clip;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr)
      r_mem[r_wptr] <= w_sat;
  end

endmodule

// File: tb/tb_fir_out_requant_decim.sv
// Scoreboard bench for fir_out_requant_decim: one DECIM_FACTOR=1 instance and one DECIM_FACTOR=3 instance.
module tb_fir_out_requant_decim;

  localparam int IW = 33;
  localparam int OW = 16;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] din;
  logic          v1, v3, ready;
  logic [OW-1:0] dout1, dout3;
  logic          dv1, dv3, sat1, sat3, ovf1, ovf3;
  logic [2:0]    fill1, fill3;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  longint rvec[4] = '{16384, 81920, -16384, 49152};
`ifdef FIR_REQUANT_CONVERGENT_EN
  int     rexp[4] = '{0, 2, 0, 2};
`else
  int     rexp[4] = '{1, 3, 0, 2};
`endif
  longint svec[3] = '{64'sd2147483648, -64'sd4294967296, 64'sd1073709056};
  int     sdat[3] = '{32767, -32768, 32767};
  int     sexp[3] = '{1, 1, 0};

  fir_out_requant_decim #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FRAC_SHIFT(15),
                          .DECIM_FACTOR(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(v1),
    .dout(dout1), .dout_valid(dv1), .dout_ready(ready),
    .sat_pulse(sat1), .overflow(ovf1), .fill(fill1));

  fir_out_requant_decim #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FRAC_SHIFT(15),
                          .DECIM_FACTOR(3), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .reset(reset), .din(din), .din_valid(v3),
    .dout(dout3), .dout_valid(dv3), .dout_ready(ready),
    .sat_pulse(sat3), .overflow(ovf3), .fill(fill3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A pop happens at the next rising edge whenever valid && ready is seen here.
  always @(negedge clk) begin
    if (!reset) begin
      if (dv1 && ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected: got %0d expected none", $signed(dout1));
        end else begin
          e1 = q1.pop_front();
          chk("dut1_dout", $signed(dout1), e1.data);
          if (e1.cyc >= 0) chk("dut1_latency", cyc, e1.cyc);
        end
      end
      if (dv3 && ready) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut3_unexpected: got %0d expected none", $signed(dout3));
        end else begin
          e3 = q3.pop_front();
          chk("dut3_dout", $signed(dout3), e3.data);
          if (e3.cyc >= 0) chk("dut3_latency", cyc, e3.cyc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; din = '0; v1 = 1'b0; v3 = 1'b0; ready = 1'b0;
    repeat (3) tick();
    chk("rst_dout", dout1, 0);
    chk("rst_valid", dv1, 0);
    chk("rst_sat", sat1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_fill", fill1, 0);
    chk("rst_fill3", fill3, 0);
    reset = 1'b0;

    // rounding, back to back
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = IW'(rvec[i]); v1 = 1'b1;
      q1.push_back('{rexp[i], cyc + 3});
      tick();
    end
    v1 = 1'b0;
    repeat (5) tick();

    // saturation and the one-cycle clip pulse
    for (int i = 0; i < 3; i++) begin
      din = IW'(svec[i]); v1 = 1'b1;
      q1.push_back('{sdat[i], cyc + 3});
      tick();
      v1 = 1'b0;
      tick(); tick();
      chk("sat_pulse_on", sat1, sexp[i]);
      tick();
      chk("sat_pulse_off", sat1, 0);
    end
    repeat (3) tick();

    // decimation by 3 with irregular idle gaps
    for (int i = 1; i <= 6; i++) begin
      din = IW'(longint'(i) <<< 15); v3 = 1'b1;
      if ((i - 1) % 3 == 0) q3.push_back('{i, cyc + 3});
      tick();
      v3 = 1'b0;
      repeat (i % 3 + 1) tick();
    end
    repeat (5) tick();

    // backpressure and overflow
    ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      din = IW'(longint'(10 + j) <<< 15); v1 = 1'b1;
      if (j < 4) q1.push_back('{10 + j, -1});
      tick();
    end
    v1 = 1'b0;
    chk("bp_fill_4th", fill1, 4);
    chk("bp_ovf_before_5th", ovf1, 0);
    tick();
    chk("bp_fill_5th", fill1, 4);
    chk("bp_ovf_5th", ovf1, 1);
    repeat (3) tick();
    chk("bp_fill_hold", fill1, 4);
    ready = 1'b1;
    repeat (6) tick();
    chk("bp_fill_drained", fill1, 0);
    chk("bp_ovf_sticky", ovf1, 1);

    // full FIFO with simultaneous read and write
    ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_ovf_cleared", ovf1, 0);
    for (int j = 0; j < 5; j++) begin
      din = IW'(longint'(20 + j) <<< 15); v1 = 1'b1;
      q1.push_back('{20 + j, -1});
      tick();
    end
    v1 = 1'b0;
    tick();
    chk("rw_fill_full", fill1, 4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rw_fill_same", fill1, 4);
    chk("rw_no_ovf", ovf1, 0);
    repeat (2) tick();
    chk("rw_fill_hold", fill1, 4);
    ready = 1'b1;
    repeat (6) tick();
    chk("rw_fill_drained", fill1, 0);
    chk("rw_ovf_final", ovf1, 0);

    // reset with three buffered and two in flight
    ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      din = IW'(longint'(30 + j) <<< 15); v1 = 1'b1;
      tick();
    end
    v1 = 1'b0;
    chk("mr_fill_before", fill1, 3);
    reset = 1'b1;
    tick();
    chk("mr_dout", dout1, 0);
    chk("mr_valid", dv1, 0);
    chk("mr_sat", sat1, 0);
    chk("mr_ovf", ovf1, 0);
    chk("mr_fill", fill1, 0);
    reset = 1'b0; ready = 1'b1;
    repeat (6) tick();
    chk("mr_no_stale", fill1, 0);
    din = IW'(longint'(7) <<< 15); v1 = 1'b1;
    q1.push_back('{7, cyc + 3});
    tick();
    v1 = 1'b0;
    repeat (5) tick();

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_out_requant_decim.md
# fir_out_requant_decim

Output conditioning stage that sits directly downstream of the FIR filter core. It accepts the full-precision signed filter output (one sample per `din_valid`, no backpressure toward the filter) and keeps every `DECIM_FACTOR`-th sample. Each kept sample is rounded and saturated to `OUTPUT_WIDTH`, then buffered in a small FIFO. A ready/valid interface drives the consumer, which may stall. One instance is used per I/Q rail.

## Interface
Parameters:
- `INPUT_WIDTH`, 33: width of signed filter output `din`.
- `OUTPUT_WIDTH`, 16: width of signed `dout`. Must satisfy `OUTPUT_WIDTH <= INPUT_WIDTH - FRAC_SHIFT`.
- `FRAC_SHIFT`, 15: number of LSBs discarded by rounding. Must be ≥1.
- `DECIM_FACTOR`, 2: keep 1 of N input samples. Must be ≥1; 1 means pass-through.
- `FIFO_DEPTH`, 4: output buffer entries. Must be a power of 2, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `din`  in  INPUT_WIDTH  signed filter output sample.
- `din_valid`  in  1  `din` valid this cycle; cannot be stalled.
- `dout`  out  OUTPUT_WIDTH  signed requantized sample (FIFO head).
- `dout_valid`  out  1  FIFO non-empty.
- `dout_ready`  in  1  consumer accepts `dout` when `dout_valid && dout_ready`.
- `sat_pulse`  out  1  one-cycle pulse when the sample written to the FIFO this cycle was clipped.
- `overflow`  out  1  sticky; a kept sample was dropped because the FIFO was full.
- `fill`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Phase counter** runs 0..DECIM_FACTOR-1 and advances only on `din_valid`, wrapping to 0. A sample is kept when `din_valid && phase == 0`. Idle cycles do not advance the phase.
- **Stage A** registers `din` and the keep flag.
- **Stage B (round)** is computed at width INPUT_WIDTH+1 so the add cannot overflow: add `2^(FRAC_SHIFT-1)`, then arithmetic-shift right by FRAC_SHIFT. This is round-half-up: ties go toward +∞, so -0.5 → 0.
- **Stage C (saturate)**:
  - Values above `2^(OUTPUT_WIDTH-1)-1` clip to max; values below `-2^(OUTPUT_WIDTH-1)` clip to min.
  - The clip flag is carried with the sample.
- **FIFO write** happens in stage C.
  - If the FIFO is full and no read occurs in the same cycle, the sample is dropped, `overflow` is set, and `sat_pulse` is not asserted.
  - A read and a write in the same cycle when the FIFO is full are both performed; nothing is dropped and `fill` is unchanged.
  - A read and a write in the same cycle when the FIFO is empty: the write is stored and no read occurs, because `dout_valid` was low.
- `dout` reads 0 whenever `dout_valid` is low.
- Pointers wrap modulo FIFO_DEPTH. `fill` ranges 0..FIFO_DEPTH.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `sat_pulse`=0, `overflow`=0, `fill`=0, phase=0. The pipeline valid flags are cleared.
- Reset asserted mid-operation discards in-flight and buffered samples on the next edge. The first `din_valid` after reset deasserts is phase 0 and is kept.
- Latency: a kept sample sampled at edge E0 is written at edge E2. `dout_valid` and `dout` update after E2, and `sat_pulse` is high for the cycle following E2.
- Throughput: one kept sample per clock (back-to-back `din_valid` with DECIM_FACTOR=1).
- A FIFO pop occurs at an edge where `dout_valid && dout_ready`. `dout` must remain stable while `dout_valid && !dout_ready`.

## Configuration
- `FIR_REQUANT_CONVERGENT_EN`:
  - Defined: stage B uses round-half-to-even. A tie (discarded bits exactly `2^(FRAC_SHIFT-1)`) rounds to the even result; non-ties are identical to round-half-up. Latency is unchanged.
  - Undefined: round-half-up as described in Operation.

## Test plan
All scenarios use defaults unless stated; "half-up" and "convergent" refer to builds without and with `FIR_REQUANT_CONVERGENT_EN`.
- **Rounding, DECIM_FACTOR=1, `dout_ready`=1:** `din` = 16384, 81920, -16384, 49152.
  - Half-up build → `dout` = 1, 3, 0, 2.
  - Convergent build → 0, 2, 0, 2.
  - In both builds, each result appears 3 edges after its input.
- **Saturation:** `din`=2^31 → `dout`=32767 with `sat_pulse`=1 for one cycle. `din`=-2^32 → `dout`=-32768 with `sat_pulse`=1. `din`=32767·2^15 → 32767 with `sat_pulse`=0.
- **Decimation, DECIM_FACTOR=3:** six `din_valid` samples 1..6·2^15 with idle gaps → `dout` = 1 then 4 only; idle cycles do not shift the phase.
- **Backpressure/overflow, DECIM_FACTOR=1:** hold `dout_ready`=0 and push 6 samples.
  - Expect `fill`=4 and `overflow`=1 from the 5th write onward, with the first 4 samples retained.
  - Releasing `dout_ready` pops them in order and `fill` returns to 0; `overflow` stays 1.
- **Full, simultaneous read/write:** with `fill`=4, pulse `dout_ready` on the same cycle a write lands → no drop, `fill` stays 4, `overflow` stays 0.
- **Reset mid-run:** assert `reset` with `fill`=3 and 2 samples in flight → next cycle all outputs are at reset values. No stale sample ever appears, and the next `din_valid` is kept.
